sha1_cycle_core: RTL and testbench

// - SHA-1 compression engine: one round per clock, 80-clock block period.
// - Message words are streamed in; chaining state persists from block to block.
// - A control generator (load/phase/init pipeline) drives a round datapath.
// - Sits behind a block scheduler that supplies padded 512-bit blocks as 16 words.

---
 rtl/sha1_pkg.sv | 42 ++++
 rtl/sha1_cycle_ctl.sv | 67 ++++++
 rtl/sha1_cycle_core.sv | 128 ++++++++++++
 tb/tb_sha1_cycle_core.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA-1 types, constants and helpers for the single-round-per-clock core.
package sha1_pkg;

  typedef logic [31:0] uint_t;

  // Round-function select as it travels down the control pipeline.
  typedef enum logic [1:0] {
    FSEL_PAR = 2'b00,
    FSEL_CH  = 2'b01,
    FSEL_MAJ = 2'b10
  } fsel_e;

  localparam uint_t IV [5] = '{32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                               32'h10325476, 32'hC3D2E1F0};

  localparam uint_t K0 = 32'h5A827999;
  localparam uint_t K1 = 32'h6ED9EBA1;
  localparam uint_t K2 = 32'h8F1BBCDC;
  localparam uint_t K3 = 32'hCA62C1D6;

  function automatic uint_t rotl(input uint_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic uint_t k_of(input logic [1:0] p);
    case (p)
      2'd0:    return K0;
      2'd1:    return K1;
      2'd2:    return K2;
      default: return K3;
    endcase
  endfunction

  function automatic fsel_e fsel_of(input logic [1:0] p);
    case (p)
      2'd0:    return FSEL_CH;
      2'd2:    return FSEL_MAJ;
      default: return FSEL_PAR;
    endcase
  endfunction

endpackage

// File: rtl/sha1_cycle_ctl.sv
// Control generator: word-load delay, round-group phase, block-start init pulses
// and the mod-80 round counter that pre-stages the chaining add.
module sha1_cycle_ctl
  import sha1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load6,
  input  logic       phase_advance7,
  output logic       load5,
  output logic [1:0] phase4,
  output logic [1:0] munged_phase2,
  output logic       init3,
  output logic       init2,
  output logic       init1,
  output logic       init13,
  output logic       init12
);

  logic [3:0] adv_sr;
  logic [1:0] phase3;
  logic [3:0] start_sr;
  logic [6:0] rnd;
  logic       synced;
  logic       start;

  // load5 still holds the previous load6 sample, so this is the rising edge.
  assign start = load6 & ~load5;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load5         <= 1'b0;
      adv_sr        <= '0;
      phase4        <= 2'd3;
      phase3        <= 2'd3;
      munged_phase2 <= FSEL_PAR;
      start_sr      <= '0;
      init3         <= 1'b0;
      init2         <= 1'b0;
      init1         <= 1'b0;
      init13        <= 1'b0;
      init12        <= 1'b0;
      rnd           <= '0;
      synced        <= 1'b0;
    end else begin
      load5         <= load6;
      adv_sr        <= {adv_sr[2:0], phase_advance7};
      if (adv_sr[3]) phase4 <= phase4 + 2'd1;
      phase3        <= phase4;
      munged_phase2 <= fsel_of(phase3);
      start_sr      <= {start_sr[2:0], start};
      init3         <= start_sr[3];
      init2         <= init3;
      init1         <= init2;
      // rnd names the round executed at the end of the current clock.
      if (init2) begin
        rnd    <= '0;
        synced <= 1'b1;
      end else if (synced) begin
        rnd <= (rnd == 7'd79) ? 7'd0 : rnd + 7'd1;
      end
      init13 <= synced & ~init2 & (rnd == 7'd67);
      init12 <= synced & ~init2 & (rnd == 7'd68);
    end
  end

endmodule

// File: rtl/sha1_cycle_core.sv
// SHA-1 compression core: one round per clock, streamed message words,
// chaining value folded in at each round-0 edge.
module sha1_cycle_core
  import sha1_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load6,
  input  logic        phase_advance7,
  input  logic [31:0] din,
  output logic [31:0] r
);

  logic       load5;
  logic [1:0] phase4;
  logic [1:0] munged_phase2;
  logic       init3, init2, init1, init13, init12;

  sha1_cycle_ctl u_ctl (
    .clk            (clk),
    .rst_n          (rst_n),
    .load6          (load6),
    .phase_advance7 (phase_advance7),
    .load5          (load5),
    .phase4         (phase4),
    .munged_phase2  (munged_phase2),
    .init3          (init3),
    .init2          (init2),
    .init1          (init1),
    .init13         (init13),
    .init12         (init12)
  );

  uint_t      w [16];
  uint_t      w_d [5];
  uint_t      a, b, c, d, e;
  uint_t      h [5];
  uint_t      h_op [5];
  uint_t      k3, k2, k1;
  logic [1:0] fsel1;
  logic       skip_add;
  logic       first_block;
  logic       active;

  uint_t w_next;
  uint_t s [5];
  uint_t hn [5];
  uint_t a_in, b_in, c_in, d_in, e_in;
  uint_t f, t;

  always_comb begin
    w_next = load5 ? din : rotl(w[2] ^ w[7] ^ w[13] ^ w[15], 1);
    s[0] = a;
    s[1] = b;
    s[2] = c;
    s[3] = d;
    s[4] = e;
    for (int i = 0; i < 5; i++) begin
      hn[i] = skip_add ? h_op[i] : h_op[i] + s[i];
    end
    // Round 0 starts from the freshly chained H rather than the working regs.
    a_in = init1 ? hn[0] : a;
    b_in = init1 ? hn[1] : b;
    c_in = init1 ? hn[2] : c;
    d_in = init1 ? hn[3] : d;
    e_in = init1 ? hn[4] : e;
    case (fsel1)
      FSEL_CH:  f = (b_in & c_in) | (~b_in & d_in);
      FSEL_MAJ: f = (b_in & c_in) | (b_in & d_in) | (c_in & d_in);
      default:  f = b_in ^ c_in ^ d_in;
    endcase
    t = rotl(a_in, 5) + f + e_in + k1 + w_d[4];
  end

  assign r = a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
      for (int i = 0; i < 5; i++) begin
        w_d[i]  <= '0;
        h[i]    <= IV[i];
        h_op[i] <= IV[i];
      end
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      e           <= '0;
      k3          <= K3;
      k2          <= K3;
      k1          <= K3;
      fsel1       <= FSEL_PAR;
      skip_add    <= 1'b1;
      first_block <= 1'b1;
      active      <= 1'b0;
    end else begin
      w[0] <= w_next;
      for (int i = 1; i < 16; i++) w[i] <= w[i-1];
      // Five-clock delay aligns each schedule word with its round.
      w_d[0] <= w[0];
      for (int i = 1; i < 5; i++) w_d[i] <= w_d[i-1];
      k3    <= k_of(phase4);
      k2    <= k3;
      k1    <= k2;
      fsel1 <= munged_phase2;
      // Operands of the chaining add settle well before round 0; init3/init2
      // cover a block restarted before the counter reaches init13/init12.
      if (init13 | init3) skip_add <= first_block;
      if (init12 | init2) begin
        for (int i = 0; i < 5; i++) h_op[i] <= h[i];
      end
      if (init1) begin
        for (int i = 0; i < 5; i++) h[i] <= hn[i];
        first_block <= 1'b0;
        active      <= 1'b1;
      end
      if (active | init1) begin
        a <= t;
        b <= a_in;
        c <= rotl(b_in, 30);
        d <= c_in;
        e <= d_in;
      end
    end
  end

endmodule

// File: tb/tb_sha1_cycle_core.sv
// Bench for sha1_cycle_core: "abc" rounds and digest, phase wrap, mid-block
// reset and din-filler immunity, with an edge-stamped expected queue for r.
module tb_sha1_cycle_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load6 = 1'b0;
  logic        phase_advance7 = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] r;

  sha1_cycle_core dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load6          (load6),
    .phase_advance7 (phase_advance7),
    .din            (din),
    .r              (r)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          edge_cnt = 0;
  logic [31:0] exp_q[$];
  int          exp_edge_q[$];
  logic [31:0] msg [32];
  logic [31:0] rec [200];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: each entry names the posedge after which r must hold it.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_edge_q[0] == edge_cnt - 1) begin
      logic [31:0] v;
      v = exp_q.pop_front();
      void'(exp_edge_q.pop_front());
      chk("sb_r", r, v);
    end
  end

  task automatic drain_check();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_edge_q.delete();
  endtask

  task automatic do_reset();
    load6 = 1'b0;
    phase_advance7 = 1'b0;
    din = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_r", r, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_r", r, 32'h0);
  endtask

  // Free-running 80-clock period; iteration 0 is the pulse-79 slot of the
  // period before the first block, so round 0 runs in phase 0.
  // mode 1: expect abc r values, 2: record r, 3: expect recorded r.
  task automatic drive_run(input int ncyc, input int nblk, input logic [31:0] filler,
                           input int mode);
    int pos, blk, e_now;
    for (int n = 0; n < ncyc; n++) begin
      pos = (n + 79) % 80;
      blk = (n + 79) / 80 - 1;
      phase_advance7 = (pos % 20 == 19);
      load6 = (blk >= 0 && blk < nblk && pos < 16);
      din = (blk >= 0 && blk < nblk && pos >= 1 && pos <= 16) ? msg[blk*16 + pos - 1] : filler;
      e_now = edge_cnt;
      if (mode == 1 && n == 1) begin
        if (8 < ncyc) begin
          exp_q.push_back(32'h0116FC33);
          exp_edge_q.push_back(e_now + 7);
        end
        if (87 < ncyc) begin
          exp_q.push_back(32'h42541B35);
          exp_edge_q.push_back(e_now + 86);
        end
      end
      if (mode == 3) begin
        exp_q.push_back(rec[n]);
        exp_edge_q.push_back(e_now);
      end
      @(negedge clk);
      if (mode == 2) rec[n] = r;
    end
    phase_advance7 = 1'b0;
    load6 = 1'b0;
    din = '0;
  endtask

  initial begin
    logic [1:0] fs_exp [4];
    logic [31:0] digest [5];
    fs_exp = '{2'b01, 2'b00, 2'b10, 2'b00};
    digest = '{32'hA9993E36, 32'h4706816A, 32'hBA3E2571, 32'h7850C26C, 32'h9CD0D89D};
    for (int i = 0; i < 32; i++) msg[i] = '0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    msg[16] = 32'h61626380;
    msg[31] = 32'h00000018;

    @(negedge clk);
    do_reset();

    // Two back-to-back "abc" blocks; H after block 2 round 0 is the digest.
    drive_run(100, 2, 32'h0, 1);
    drain_check();
    for (int i = 0; i < 5; i++) chk($sformatf("h%0d", i), dut.h[i], digest[i]);

    // Phase wrap with no block in flight.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      phase_advance7 = 1'b1;
      @(negedge clk);
      phase_advance7 = 1'b0;
      repeat (7) @(negedge clk);
      chk($sformatf("phase%0d", i), {30'b0, dut.phase4}, 32'(i));
      chk($sformatf("fsel%0d", i), {30'b0, dut.munged_phase2}, {30'b0, fs_exp[i]});
    end

    // Reset during round 40, then a fresh "abc" block must reuse the IV.
    do_reset();
    drive_run(48, 1, 32'h0, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_r", r, 32'h0);
    chk("rst_mid_h0", dut.h[0], 32'h67452301);
    @(negedge clk);
    do_reset();
    drive_run(90, 1, 32'h0, 1);
    drain_check();

    // din outside load windows must not matter.
    for (int i = 0; i < 32; i++) msg[i] = $urandom;
    do_reset();
    drive_run(170, 2, 32'h0, 2);
    do_reset();
    drive_run(170, 2, 32'h00001234, 3);
    repeat (2) @(negedge clk);
    drain_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
